// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives a two-input gate through the vectors {A,B} = 00, 01, 10, 11. After a
// programmable settle time it samples the gate output for each vector, then
// reports the captured truth table and how it compares with EXPECTED.
module truth_table_sweeper #(
    parameter logic [3:0] EXPECTED = 4'b1110,
    parameter int         SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With no settle time, a freshly driven vector is sampled on the very next edge.
    localparam state_t     AFTER_DRIVE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [3:0] captured_nxt;
    logic       last_vec;
    logic       settle_end;

    assign last_vec   = (idx == 2'd3);
    assign settle_end = (cnt == SETTLE_LAST);

    // Captured table with the current vector's bit replaced by the live gate output.
    // On the final sample, pass is judged from this value so that it already
    // includes the bit sampled on the edge that enters DONE.
    always_comb begin
        captured_nxt      = captured;
        captured_nxt[idx] = Out;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so requests made
    // during a sweep are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = AFTER_DRIVE;
                end
            end
            S_SETTLE: begin
                if (settle_end) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (last_vec) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = AFTER_DRIVE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Vector index, settle counter, gate drive, and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            cnt       <= 4'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            captured  <= 4'b0000;
            fail_mask <= 4'b0000;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= 2'd0;
                        cnt       <= 4'd0;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        captured  <= 4'b0000;
                        fail_mask <= 4'b0000;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_end) begin
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    captured       <= captured_nxt;
                    fail_mask[idx] <= Out ^ EXPECTED[idx];
                    if (last_vec) begin
                        // A/B stay at 11 through the DONE cycle.
                        done <= 1'b1;
                        pass <= (captured_nxt == EXPECTED);
                    end else begin
                        idx    <= idx + 2'd1;
                        {A, B} <= idx + 2'd1;
                    end
                end
                S_DONE: begin
                    // pass, captured and fail_mask hold until the next accepted start.
                    busy <= 1'b0;
                    A    <= 1'b0;
                    B    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. There are two instances:
//   dut0: SETTLE=2, EXPECTED=OR (4'b1110)
//   dut1: SETTLE=0, EXPECTED=AND (4'b1000)
// Each gate under test is modelled as a lookup into a programmable 4-bit truth table.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n, start0, start1;
    logic       a0, b0, out0, busy0, done0, pass0;
    logic       a1, b1, out1, busy1, done1, pass1;
    logic [3:0] cap0, fm0, cap1, fm1;
    logic [3:0] gate0, gate1;
    logic       sel;
    logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
    logic [3:0] obs_cap, obs_fm;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign out0 = gate0[{a0, b0}];
    assign out1 = gate1[{a1, b1}];

    assign obs_a    = sel ? a1    : a0;
    assign obs_b    = sel ? b1    : b0;
    assign obs_busy = sel ? busy1 : busy0;
    assign obs_done = sel ? done1 : done0;
    assign obs_pass = sel ? pass1 : pass0;
    assign obs_cap  = sel ? cap1  : cap0;
    assign obs_fm   = sel ? fm1   : fm0;

    truth_table_sweeper #(.EXPECTED(4'b1110), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst0_n), .start(start0), .A(a0), .B(b0), .Out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .captured(cap0), .fail_mask(fm0)
    );

    truth_table_sweeper #(.EXPECTED(4'b1000), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .A(a1), .B(b1), .Out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .captured(cap1), .fail_mask(fm1)
    );

    typedef struct {
        bit         s;
        logic [3:0] gate;
        logic [3:0] cap;
        logic [3:0] fm;
        logic       pass;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start1 = v;
        else   start0 = v;
    endtask

    // Runs one sweep on the selected instance and checks every cycle against
    // the timing rule: vector k is driven for SETTLE+1 cycles starting at
    // edge E0 + k*(SETTLE+1), and done follows at E0 + 4*(SETTLE+1).
    task automatic sweep(input bit s, input logic [3:0] g, input bit repulse);
        int         per;
        int         total;
        logic [3:0] expw;
        logic [3:0] ecap;
        logic [3:0] efm;
        logic [1:0] eab;
        per   = s ? 1 : 3;
        total = 4 * per;
        expw  = s ? 4'b1000 : 4'b1110;
        sel   = s;
        if (s) gate1 = g;
        else   gate0 = g;
        @(negedge clk);
        set_start(s, 1'b1);
        for (int c = 0; c <= total + 1; c++) begin
            @(negedge clk);
            if (c == 0) set_start(s, 1'b0);
            if (repulse && c == 4) set_start(s, 1'b1);
            if (repulse && c == 5) set_start(s, 1'b0);
            if (c < total)       eab = 2'(c / per);
            else if (c == total) eab = 2'd3;
            else                 eab = 2'd0;
            ecap = 4'b0000;
            efm  = 4'b0000;
            for (int j = 0; j < 4; j++) begin
                if ((j + 1) * per <= c) begin
                    ecap[j] = g[j];
                    efm[j]  = g[j] ^ expw[j];
                end
            end
            chk($sformatf("ab_s%0d_c%0d", s, c), 4'({obs_a, obs_b}), 4'(eab));
            chk($sformatf("busy_s%0d_c%0d", s, c), 4'(obs_busy), 4'(c <= total));
            chk($sformatf("done_s%0d_c%0d", s, c), 4'(obs_done), 4'(c == total));
            chk($sformatf("cap_s%0d_c%0d", s, c), obs_cap, ecap);
            chk($sformatf("fm_s%0d_c%0d", s, c), obs_fm, efm);
            chk($sformatf("pass_s%0d_c%0d", s, c), 4'(obs_pass), 4'((c >= total) && (g == expw)));
        end
    endtask

    initial begin
        bit         seen;
        logic [3:0] g;

        vecs[0] = '{1'b0, 4'b1110, 4'b1110, 4'b0000, 1'b1};  // OR gate
        vecs[1] = '{1'b0, 4'b0000, 4'b0000, 4'b1110, 1'b0};  // Out stuck at 0
        vecs[2] = '{1'b0, 4'b0110, 4'b0110, 4'b1000, 1'b0};  // XOR instead of OR
        vecs[3] = '{1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1};  // AND, no settle
        vecs[4] = '{1'b1, 4'b1111, 4'b1111, 4'b0111, 1'b0};  // Out stuck at 1
        vecs[5] = '{1'b0, 4'b0111, 4'b0111, 4'b1001, 1'b0};  // NAND

        sel    = 1'b0;
        gate0  = 4'b1110;
        gate1  = 4'b1000;
        start0 = 1'b0;
        start1 = 1'b0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs0", 4'({a0, b0, busy0, done0}), 4'b0000);
        chk("reset_pass0", 4'(pass0), 4'b0000);
        chk("reset_cap0", cap0, 4'b0000);
        chk("reset_fm0", fm0, 4'b0000);
        chk("reset_outs1", 4'({a1, b1, busy1, done1}), 4'b0000);
        chk("reset_cap1", cap1, 4'b0000);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);

        // Directed table of gate behaviours.
        for (int i = 0; i < 6; i++) begin
            sweep(vecs[i].s, vecs[i].gate, 1'b0);
            sel = vecs[i].s;
            #1;
            chk($sformatf("tbl%0d_cap", i), obs_cap, vecs[i].cap);
            chk($sformatf("tbl%0d_fm", i), obs_fm, vecs[i].fm);
            chk($sformatf("tbl%0d_pass", i), 4'(obs_pass), 4'(vecs[i].pass));
        end

        // A start re-pulsed mid-sweep must not disturb timing or add a done pulse.
        sweep(1'b0, 4'b1110, 1'b1);

        // With start held high, the next sweep is accepted at E14.
        sel   = 1'b0;
        gate0 = 4'b1110;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c == 12) chk("held_done_e12", 4'(done0), 4'b0001);
            if (c == 13) chk("held_idle_e13", 4'({busy0, done0}), 4'b0000);
            if (c == 14) begin
                chk("held_busy_e14", 4'(busy0), 4'b0001);
                chk("held_cap_e14", cap0, 4'b0000);
                chk("held_ab_e14", 4'({a0, b0}), 4'b0000);
            end
        end
        start0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        chk("held_second_done", 4'(seen), 4'b0001);
        chk("held_second_pass", 4'(pass0), 4'b0001);
        @(negedge clk);

        // The result holds while idle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold_state_%0d", i), 4'({pass0, busy0, a0, b0}), 4'b1000);
            chk($sformatf("hold_cap_%0d", i), cap0, 4'b1110);
            chk($sformatf("hold_fm_%0d", i), fm0, 4'b0000);
        end

        // Reset asserted just after E7 aborts the sweep at once.
        gate0 = 4'b1110;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst0_n = 1'b0;
        #1;
        chk("abort_outs", 4'({a0, b0, busy0, done0}), 4'b0000);
        chk("abort_pass", 4'(pass0), 4'b0000);
        chk("abort_cap", cap0, 4'b0000);
        chk("abort_fm", fm0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone_%0d", i), 4'({busy0, done0}), 4'b0000);
        end
        rst0_n = 1'b1;
        sweep(1'b0, 4'b1110, 1'b0);
        chk("after_abort_pass", 4'(pass0), 4'b0001);

        // Random gate behaviours checked against the timing and result model.
        for (int i = 0; i < 8; i++) begin
            g = 4'($urandom_range(0, 15));
            sweep(i[0], g, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
